// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// A clock divider produces a pixel tick. The x/y position counters advance on that tick.
// Every decoded output is a flop fed from the next-state position, so each one
// changes on the same edge as the counters and always describes the same pixel.
`timescale 1ns/1ps

module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned HS_POL   = 0,
    parameter int unsigned VS_POL   = 0,
    parameter int unsigned CLK_DIV  = 1,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned XW      = $clog2(H_TOTAL),
    localparam int unsigned YW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          pix_stb,
    output logic [XW-1:0] counter_x,
    output logic [YW-1:0] counter_y,
    output logic          hsync,
    output logic          vsync,
    output logic          in_display_area,
    output logic          hblank,
    output logic          vblank,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_cnt
);

    localparam int unsigned DW = (CLK_DIV > 32'd1) ? $clog2(CLK_DIV) : 32'd1;

    localparam logic [DW-1:0] DIV_ZERO = DW'(32'd0);
    localparam logic [DW-1:0] DIV_ONE  = DW'(32'd1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 32'd1);
    localparam logic [XW-1:0] X_ZERO   = XW'(32'd0);
    localparam logic [XW-1:0] X_ONE    = XW'(32'd1);
    localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 32'd1);
    localparam logic [YW-1:0] Y_ZERO   = YW'(32'd0);
    localparam logic [YW-1:0] Y_ONE    = YW'(32'd1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 32'd1);

    // Sync windows in full 32-bit arithmetic so a zero back porch cannot overflow XW/YW.
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    localparam logic HS_ON = 1'(HS_POL);
    localparam logic VS_ON = 1'(VS_POL);

    logic [DW-1:0] div_r;
    logic          tick_s;
    logic [XW-1:0] x_nxt_s;
    logic [YW-1:0] y_nxt_s;
    logic          frame_wrap_s;
    logic          hsync_nxt_s;
    logic          vsync_nxt_s;
    logic          hblank_nxt_s;
    logic          vblank_nxt_s;
    logic          line_start_nxt_s;

    assign tick_s = (div_r == DIV_LAST);

    // Pixel-clock divider: counts clk cycles within one pixel period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r <= DIV_ZERO;
        end else if (tick_s) begin
            div_r <= DIV_ZERO;
        end else begin
            div_r <= div_r + DIV_ONE;
        end
    end

    // Next-state position: advance x on tick and carry into y at the end of each line.
    always_comb begin
        x_nxt_s      = counter_x;
        y_nxt_s      = counter_y;
        frame_wrap_s = 1'b0;
        if (tick_s) begin
            if (counter_x == X_LAST) begin
                x_nxt_s = X_ZERO;
                if (counter_y == Y_LAST) begin
                    y_nxt_s      = Y_ZERO;
                    frame_wrap_s = 1'b1;
                end else begin
                    y_nxt_s = counter_y + Y_ONE;
                end
            end else begin
                x_nxt_s = counter_x + X_ONE;
            end
        end else begin
            x_nxt_s = counter_x;
            y_nxt_s = counter_y;
        end
    end

    // Region decode of the next-state position; it feeds the output flops.
    always_comb begin
        hblank_nxt_s     = (32'(x_nxt_s) >= H_ACTIVE);
        vblank_nxt_s     = (32'(y_nxt_s) >= V_ACTIVE);
        line_start_nxt_s = (x_nxt_s == X_ZERO);
        hsync_nxt_s      = ~HS_ON;
        vsync_nxt_s      = ~VS_ON;
        if ((32'(x_nxt_s) >= HS_START) && (32'(x_nxt_s) < HS_END)) begin
            hsync_nxt_s = HS_ON;
        end else begin
            hsync_nxt_s = ~HS_ON;
        end
        if ((32'(y_nxt_s) >= VS_START) && (32'(y_nxt_s) < VS_END)) begin
            vsync_nxt_s = VS_ON;
        end else begin
            vsync_nxt_s = ~VS_ON;
        end
    end

    // Output registers: position, decoded levels, pixel strobe and frame counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter_x       <= X_LAST;
            counter_y       <= Y_LAST;
            pix_stb         <= 1'b0;
            hsync           <= ~HS_ON;
            vsync           <= ~VS_ON;
            in_display_area <= 1'b0;
            hblank          <= 1'b1;
            vblank          <= 1'b1;
            line_start      <= 1'b0;
            frame_start     <= 1'b0;
            frame_cnt       <= 8'd0;
        end else begin
            counter_x       <= x_nxt_s;
            counter_y       <= y_nxt_s;
            pix_stb         <= tick_s;
            hsync           <= hsync_nxt_s;
            vsync           <= vsync_nxt_s;
            in_display_area <= ~hblank_nxt_s & ~vblank_nxt_s;
            hblank          <= hblank_nxt_s;
            vblank          <= vblank_nxt_s;
            line_start      <= line_start_nxt_s;
            frame_start     <= line_start_nxt_s & (y_nxt_s == Y_ZERO);
            if (frame_wrap_s) begin
                frame_cnt <= frame_cnt + 8'd1;
            end else begin
                frame_cnt <= frame_cnt;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized-reset bench for vga_timing_gen.
// Four geometries run side by side. Each output is compared every clk against an
// arithmetic model: the pixel index is derived from the count of edges since reset release.
`timescale 1ns/1ps

module tb_vga_timing_gen;

    typedef struct {
        int ha, hf, hsw, hb, va, vf, vsw, vb, hp, vp, cd;
    } geom_t;

    typedef struct {
        logic [31:0] x, y, fc;
        logic        stb, hs, vs, ide, hb, vb, ls, fs;
    } outs_t;

    logic clk;
    logic rst;
    int   k;          // rising edges since reset release
    int   n_checks;
    int   n_pass;
    bit   run_chk;
    int   last_def_ls, last_div_ls, last_small_fs;

    // default geometry, CLK_DIV = 1
    logic d_stb, d_hs, d_vs, d_ide, d_hb, d_vb, d_ls, d_fs;
    logic [9:0] d_x, d_y;
    logic [7:0] d_fc;
    // default horizontal, short vertical, CLK_DIV = 3
    logic v_stb, v_hs, v_vs, v_ide, v_hb, v_vb, v_ls, v_fs;
    logic [9:0] v_x;
    logic [2:0] v_y;
    logic [7:0] v_fc;
    // small geometry, positive polarities
    logic s_stb, s_hs, s_vs, s_ide, s_hb, s_vb, s_ls, s_fs;
    logic [2:0] s_x, s_y;
    logic [7:0] s_fc;
    // short horizontal, default vertical, CLK_DIV = 2
    logic t_stb, t_hs, t_vs, t_ide, t_hb, t_vb, t_ls, t_fs;
    logic [2:0] t_x;
    logic [9:0] t_y;
    logic [7:0] t_fc;

    vga_timing_gen u_def (
        .clk(clk), .rst(rst), .pix_stb(d_stb), .counter_x(d_x), .counter_y(d_y),
        .hsync(d_hs), .vsync(d_vs), .in_display_area(d_ide), .hblank(d_hb), .vblank(d_vb),
        .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fc));

    vga_timing_gen #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .CLK_DIV(3)) u_div (
        .clk(clk), .rst(rst), .pix_stb(v_stb), .counter_x(v_x), .counter_y(v_y),
        .hsync(v_hs), .vsync(v_vs), .in_display_area(v_ide), .hblank(v_hb), .vblank(v_vb),
        .line_start(v_ls), .frame_start(v_fs), .frame_cnt(v_fc));

    vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1),
                     .V_SYNC(1), .V_BP(1), .HS_POL(1), .VS_POL(1)) u_small (
        .clk(clk), .rst(rst), .pix_stb(s_stb), .counter_x(s_x), .counter_y(s_y),
        .hsync(s_hs), .vsync(s_vs), .in_display_area(s_ide), .hblank(s_hb), .vblank(s_vb),
        .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fc));

    vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .CLK_DIV(2)) u_tall (
        .clk(clk), .rst(rst), .pix_stb(t_stb), .counter_x(t_x), .counter_y(t_y),
        .hsync(t_hs), .vsync(t_vs), .in_display_area(t_ide), .hblank(t_hb), .vblank(t_vb),
        .line_start(t_ls), .frame_start(t_fs), .frame_cnt(t_fc));

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter since reset release, used by the reference model
    always @(posedge clk or posedge rst) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (k=%0d, t=%0t)", tag, obs, exp, k, $time);
        end
    endtask

    function automatic geom_t geom(int ha, int hf, int hsw, int hb, int va, int vf,
                                   int vsw, int vb, int hp, int vp, int cd);
        geom_t g;
        g.ha = ha; g.hf = hf; g.hsw = hsw; g.hb = hb;
        g.va = va; g.vf = vf; g.vsw = vsw; g.vb = vb;
        g.hp = hp; g.vp = vp; g.cd = cd;
        return g;
    endfunction

    // Reference: the pixel index is the number of completed ticks minus one
    function automatic outs_t model(geom_t g, int edges, bit in_rst);
        outs_t e;
        int htot, vtot, t, q;
        htot = g.ha + g.hf + g.hsw + g.hb;
        vtot = g.va + g.vf + g.vsw + g.vb;
        t = edges / g.cd;
        if (in_rst || t == 0) begin
            e.x = htot - 1; e.y = vtot - 1; e.fc = 0; e.stb = 1'b0;
            e.hs = !g.hp[0]; e.vs = !g.vp[0];
            e.ide = 1'b0; e.hb = 1'b1; e.vb = 1'b1; e.ls = 1'b0; e.fs = 1'b0;
        end else begin
            q    = t - 1;
            e.x  = q % htot;
            e.y  = (q / htot) % vtot;
            e.fc = (q / (htot * vtot) + 1) % 256;
            e.stb = ((edges % g.cd) == 0);
            e.hs = (int'(e.x) >= g.ha + g.hf && int'(e.x) < g.ha + g.hf + g.hsw) ? g.hp[0] : !g.hp[0];
            e.vs = (int'(e.y) >= g.va + g.vf && int'(e.y) < g.va + g.vf + g.vsw) ? g.vp[0] : !g.vp[0];
            e.hb = (int'(e.x) >= g.ha);
            e.vb = (int'(e.y) >= g.va);
            e.ide = !e.hb && !e.vb;
            e.ls = (e.x == 0);
            e.fs = (e.x == 0) && (e.y == 0);
        end
        return e;
    endfunction

    function automatic outs_t mk(logic stb, logic [31:0] x, logic [31:0] y, logic hs, logic vs,
                                 logic ide, logic hb, logic vb, logic ls, logic fs, logic [31:0] fc);
        outs_t o;
        o.stb = stb; o.x = x; o.y = y; o.hs = hs; o.vs = vs; o.ide = ide;
        o.hb = hb; o.vb = vb; o.ls = ls; o.fs = fs; o.fc = fc;
        return o;
    endfunction

    task automatic cmp_inst(input string n, input geom_t g, input outs_t o);
        outs_t e;
        e = model(g, k, rst);
        check({n, ".pix_stb"}, 32'(o.stb), 32'(e.stb));
        check({n, ".x"}, o.x, e.x);
        check({n, ".y"}, o.y, e.y);
        check({n, ".hsync"}, 32'(o.hs), 32'(e.hs));
        check({n, ".vsync"}, 32'(o.vs), 32'(e.vs));
        check({n, ".in_disp"}, 32'(o.ide), 32'(e.ide));
        check({n, ".hblank"}, 32'(o.hb), 32'(e.hb));
        check({n, ".vblank"}, 32'(o.vb), 32'(e.vb));
        check({n, ".line_start"}, 32'(o.ls), 32'(e.ls));
        check({n, ".frame_start"}, 32'(o.fs), 32'(e.fs));
        check({n, ".frame_cnt"}, o.fc, e.fc);
    endtask

    task automatic check_all();
        cmp_inst("def", geom(640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 1),
                 mk(d_stb, 32'(d_x), 32'(d_y), d_hs, d_vs, d_ide, d_hb, d_vb, d_ls, d_fs, 32'(d_fc)));
        cmp_inst("div", geom(640, 16, 96, 48, 4, 1, 1, 1, 0, 0, 3),
                 mk(v_stb, 32'(v_x), 32'(v_y), v_hs, v_vs, v_ide, v_hb, v_vb, v_ls, v_fs, 32'(v_fc)));
        cmp_inst("small", geom(4, 1, 2, 1, 3, 1, 1, 1, 1, 1, 1),
                 mk(s_stb, 32'(s_x), 32'(s_y), s_hs, s_vs, s_ide, s_hb, s_vb, s_ls, s_fs, 32'(s_fc)));
        cmp_inst("tall", geom(4, 1, 2, 1, 480, 10, 2, 33, 0, 0, 2),
                 mk(t_stb, 32'(t_x), 32'(t_y), t_hs, t_vs, t_ide, t_hb, t_vb, t_ls, t_fs, 32'(t_fc)));
    endtask

    // Per-cycle scoreboard plus line/frame period measurements, sampled on the falling edge
    always @(negedge clk) begin
        if (run_chk) begin
            check_all();
            if (rst) begin
                last_def_ls = -1; last_div_ls = -1; last_small_fs = -1;
            end else begin
                if (d_stb && d_ls) begin
                    if (last_def_ls >= 0) check("def.line_period", 32'(k - last_def_ls), 32'd800);
                    last_def_ls = k;
                end
                if (v_stb && v_ls) begin
                    if (last_div_ls >= 0) check("div.line_period", 32'(k - last_div_ls), 32'd2400);
                    last_div_ls = k;
                end
                if (s_stb && s_fs) begin
                    if (last_small_fs >= 0) check("small.frame_period", 32'(k - last_small_fs), 32'd48);
                    last_small_fs = k;
                end
            end
        end
    end

    // Releases reset between edges and checks the first tick of the default instance
    task automatic release_and_check_first();
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        check("def.first_x", 32'(d_x), 32'd0);
        check("def.first_y", 32'(d_y), 32'd0);
        check("def.first_fs", 32'(d_fs), 32'd1);
        check("def.first_fc", 32'(d_fc), 32'd1);
        check("def.first_hs", 32'(d_hs), 32'd1);
    endtask

    // Asserts reset between edges and checks that the outputs react without a clock edge
    task automatic async_reset();
        #($urandom_range(1, 3));
        rst = 1'b1;
        #1;
        check("def.rst_x", 32'(d_x), 32'd799);
        check("def.rst_y", 32'(d_y), 32'd524);
        check("def.rst_fc", 32'(d_fc), 32'd0);
        check("def.rst_stb", 32'(d_stb), 32'd0);
        check("small.rst_hs", 32'(s_hs), 32'd0);
        check_all();
    endtask

    initial begin
        n_checks = 0; n_pass = 0; run_chk = 1'b0; rst = 1'b0;
        last_def_ls = -1; last_div_ls = -1; last_small_fs = -1;
        #2;
        async_reset();
        run_chk = 1'b1;
        release_and_check_first();

        // Three complete small frames after the release.
        repeat (143) @(posedge clk);
        #1;
        check("small.fc_after3", 32'(s_fc), 32'd3);
        check("small.x_after3", 32'(s_x), 32'd7);
        check("small.y_after3", 32'(s_y), 32'd5);

        // Mid-operation resets at random points.
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(50, 3000)) @(posedge clk);
            async_reset();
            repeat ($urandom_range(0, 2)) @(posedge clk);
            release_and_check_first();
        end

        // A long clean run covering a full frame of the tall geometry.
        repeat (9000) @(posedge clk);
        #1;
        check("tall.fc_full_frame", 32'(t_fc), 32'd2);
        run_chk = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator. It is the next generation of the fixed 640x480 sync generator. All porch, sync and active lengths are parameters, sync polarity is configurable, and an internal pixel-clock divider lets the block run from a faster system clock. Registered, glitch-free sync/blank/position outputs drive the video pipeline (board renderer, pixel mux) and the VGA connector.

## Interface
Parameters:
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- HS_POL, 0: asserted level of hsync (0 = active-low).
- VS_POL, 0: asserted level of vsync.
- CLK_DIV, 1: clk cycles per pixel (≥1).
- Derived: H_TOTAL = sum of the four H_* parameters; V_TOTAL likewise. XW = $clog2(H_TOTAL); YW = $clog2(V_TOTAL).

Ports:
- clk  in  1  system clock; all state is on its rising edge.
- rst  in  1  reset. Reset is asynchronous and active-high.
- pix_stb  out  1  one-clk pulse marking the first clk cycle of each new pixel position.
- counter_x  out  XW  current horizontal position, 0..H_TOTAL-1.
- counter_y  out  YW  current vertical position, 0..V_TOTAL-1.
- hsync  out  1  horizontal sync, at level HS_POL when asserted.
- vsync  out  1  vertical sync, at level VS_POL when asserted.
- in_display_area  out  1  high when counter_x < H_ACTIVE and counter_y < V_ACTIVE.
- hblank  out  1  high when counter_x ≥ H_ACTIVE.
- vblank  out  1  high when counter_y ≥ V_ACTIVE.
- line_start  out  1  high while counter_x == 0.
- frame_start  out  1  high while counter_x == 0 and counter_y == 0.
- frame_cnt  out  8  count of frames started, modulo 256.

## Operation
- Divider:
  - div runs 0..CLK_DIV-1 and wraps to 0.
  - The internal tick is true when div == CLK_DIV-1.
  - With CLK_DIV = 1, tick is true on every clk cycle.
- Position counters advance only on tick:
  - x increments; at H_TOTAL-1 it wraps to 0.
  - y increments only when x wraps; at V_TOTAL-1 it wraps to 0.
  - Terminal count is TOTAL-1, so there are exactly H_TOTAL pixels per line and V_TOTAL lines per frame.
- frame_cnt increments, with 8-bit wrap, on the tick that moves the position to (0,0).
- Region map, horizontal (vertical is identical with V_* parameters):
  - Active: [0, H_ACTIVE).
  - Front porch: [H_ACTIVE, H_ACTIVE+H_FP).
  - Sync: [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - Back porch: the remainder.
- hsync equals HS_POL inside the horizontal sync window and ~HS_POL elsewhere. vsync follows the same rule with VS_POL.
- Every decoded output (hsync, vsync, in_display_area, hblank, vblank, line_start, frame_start) is a flop. Each is computed from the next-state position, so it changes on the same edge as counter_x/counter_y and matches the position it accompanies.
- Level outputs hold for the whole pixel period (CLK_DIV clk cycles). Consumers needing single-cycle events AND them with pix_stb.
- Reset values (all asynchronous):
  - div = 0.
  - counter_x = H_TOTAL-1 and counter_y = V_TOTAL-1, i.e. the last back-porch pixel.
  - in_display_area = 0, hblank = 1, vblank = 1.
  - hsync = ~HS_POL, vsync = ~VS_POL.
  - line_start = 0, frame_start = 0, pix_stb = 0, frame_cnt = 0.
- Reset asserted mid-frame forces all of the above immediately, without waiting for a clk edge.

## Timing
- After rst falls, the first tick occurs on the CLK_DIV-th rising edge of clk. That edge moves the position to (0,0) and asserts pix_stb, line_start, frame_start and in_display_area. frame_cnt becomes 1 on the same edge.
- pix_stb is high for exactly one clk cycle per pixel period. With CLK_DIV = 1 it stays high continuously after the first tick.
- vsync, vblank and counter_y change only on the edge where x wraps to 0, together with that x change.
- Latency from tick to updated outputs: 0 cycles. Outputs are registered on the tick edge itself; there is no extra pipeline stage.
- Line period = H_TOTAL × CLK_DIV clk cycles. Frame period = H_TOTAL × V_TOTAL × CLK_DIV clk cycles.

## Test plan
- Reset values: assert rst asynchronously between edges → all outputs take their reset values immediately. Release rst with CLK_DIV = 1 → on the first edge, counter_x = 0, counter_y = 0, frame_start = 1, frame_cnt = 1, hsync = 1 (HS_POL = 0).
- Line timing (defaults): count the pixels of one line → line length is 800. hsync is 0 exactly for x = 656..751. in_display_area is 1 for x = 0..639 on y = 0 and 0 for x = 640..799.
- Frame timing (defaults): run 420000 ticks → position returns to (0,0), frame_cnt increments by 1. vsync is 0 only for y = 490..491. vblank is 1 for y = 480..524.
- Divider: CLK_DIV = 3 → pix_stb high every 3rd clk cycle. Each counter_x value is held for exactly 3 clk cycles. One line takes 2400 clk cycles.
- Small geometry, exhaustive check: H = 4/1/2/1, V = 3/1/1/1, HS_POL = 1, VS_POL = 1. Scoreboard every output against a reference model over 3 full frames → H_TOTAL = 8, V_TOTAL = 6. hsync is 1 only at x = 5..6; vsync is 1 only at y = 4. frame_cnt = 3.
- Mid-operation reset: assert rst at position (300,200) → counters immediately read (H_TOTAL-1, V_TOTAL-1) and frame_cnt = 0. After release, the first tick gives position (0,0) with frame_start = 1.
